// File: rtl/cmat_alu.sv
// cmat_alu: complex-matrix ALU (add, sub, matrix mul, Hadamard) built around one time-shared complex MAC.
// Optional feature macro CMAT_SAT_EN: saturate result components to RW bits (default: wrap to low RW bits).
module cmat_alu #(
    parameter int unsigned M  = 3,
    parameter int unsigned K  = 3,
    parameter int unsigned N  = 3,
    parameter int unsigned W  = 8,
    parameter int unsigned RW = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              a_valid,
    input  logic [2*W-1:0]    a_data,
    input  logic              b_valid,
    input  logic [2*W-1:0]    b_data,
    input  logic              res_ready,
    output logic              res_valid,
    output logic [2*RW-1:0]   res_data,
    output logic              res_last,
    output logic              busy,
    output logic              error
);
    localparam int unsigned MK     = M * K;
    localparam int unsigned KN     = K * N;
    localparam int unsigned MN     = M * N;
    localparam int unsigned ACC_W  = 2 * W + $clog2(K) + 2;
    localparam int unsigned CW     = (ACC_W > RW) ? ACC_W : RW;
    localparam int unsigned AA_W   = $clog2(MK + 1);
    localparam int unsigned BA_W   = $clog2(KN + 1);
    localparam int unsigned RA_W   = $clog2(MN + 1);
    localparam int unsigned I_W    = $clog2(M + 1);
    localparam int unsigned J_W    = $clog2(N + 1);
    localparam int unsigned KK_W   = $clog2(K + 1);
    localparam int unsigned ADEPTH = 1 << AA_W;
    localparam int unsigned BDEPTH = 1 << BA_W;
    localparam int unsigned RDEPTH = 1 << RA_W;
    localparam bit          SQUARE = (M == K) && (K == N);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_HAD = 2'b11;

    localparam logic signed [CW-1:0] SAT_MAX = {{(CW-RW+1){1'b0}}, {(RW-1){1'b1}}};
    localparam logic signed [CW-1:0] SAT_MIN = {{(CW-RW+1){1'b1}}, {(RW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_OUT} state_t;

    state_t                   r_state;
    state_t                   w_next;

    logic [2*W-1:0]           r_abuf [ADEPTH];
    logic [2*W-1:0]           r_bbuf [BDEPTH];
    logic [2*RW-1:0]          r_rbuf [RDEPTH];

    logic [1:0]               r_op;
    logic [AA_W-1:0]          r_a_cnt;
    logic [BA_W-1:0]          r_b_cnt;
    logic [I_W-1:0]           r_i;
    logic [J_W-1:0]           r_j;
    logic [KK_W-1:0]          r_k;
    logic signed [ACC_W-1:0]  r_acc_re;
    logic signed [ACC_W-1:0]  r_acc_im;
    logic [RA_W-1:0]          r_oidx;
    logic                     r_res_valid;
    logic [2*RW-1:0]          r_res_data;
    logic                     r_res_last;
    logic                     r_busy;
    logic                     r_error;

    logic                     w_legal;
    logic                     w_is_mul;
    logic                     w_a_take;
    logic                     w_b_take;
    logic                     w_a_done;
    logic                     w_b_done;
    logic                     w_k_last;
    logic                     w_col_last;
    logic                     w_row_last;
    logic                     w_cmp_last;
    logic                     w_wr_en;
    logic                     w_out_last;
    logic [AA_W-1:0]          w_a_addr;
    logic [BA_W-1:0]          w_b_addr;
    logic [RA_W-1:0]          w_r_addr;
    logic [RA_W-1:0]          w_oidx_nxt;
    logic [2*W-1:0]           w_a_el;
    logic [2*W-1:0]           w_b_el;
    logic signed [ACC_W-1:0]  w_ar;
    logic signed [ACC_W-1:0]  w_ai;
    logic signed [ACC_W-1:0]  w_br;
    logic signed [ACC_W-1:0]  w_bi;
    logic signed [ACC_W-1:0]  w_pre;
    logic signed [ACC_W-1:0]  w_pim;
    logic signed [ACC_W-1:0]  w_vre;
    logic signed [ACC_W-1:0]  w_vim;
    logic [2*RW-1:0]          w_wr_data;

    // Reduce a full-precision component to RW bits.
    function automatic logic [RW-1:0] reduce_rw(input logic signed [ACC_W-1:0] v);
`ifdef CMAT_SAT_EN
        logic signed [CW-1:0] x;
        x = CW'(v);
        if (x > SAT_MAX)      return SAT_MAX[RW-1:0];
        else if (x < SAT_MIN) return SAT_MIN[RW-1:0];
        else                  return x[RW-1:0];
`else
        return RW'(v);
`endif
    endfunction

    assign w_legal    = (op == OP_MUL) || SQUARE;
    assign w_is_mul   = (r_op == OP_MUL);
    assign w_a_take   = (r_state == S_LOAD) && a_valid && (r_a_cnt != AA_W'(MK));
    assign w_b_take   = (r_state == S_LOAD) && b_valid && (r_b_cnt != BA_W'(KN));
    assign w_a_done   = (r_a_cnt == AA_W'(MK)) || (w_a_take && (r_a_cnt == AA_W'(MK - 1)));
    assign w_b_done   = (r_b_cnt == BA_W'(KN)) || (w_b_take && (r_b_cnt == BA_W'(KN - 1)));
    assign w_k_last   = !w_is_mul || (r_k == KK_W'(K - 1));
    assign w_col_last = (r_j == J_W'(N - 1));
    assign w_row_last = (r_i == I_W'(M - 1));
    assign w_cmp_last = w_k_last && w_col_last && w_row_last;
    assign w_wr_en    = (r_state == S_COMPUTE) && w_k_last;
    assign w_out_last = (r_oidx == RA_W'(MN - 1));
    assign w_oidx_nxt = r_oidx + RA_W'(1);

    // Element-wise ops walk A[i][j]/B[i][j]; matrix mul walks A[i][k]/B[k][j].
    assign w_a_addr = AA_W'(32'(r_i) * K + (w_is_mul ? 32'(r_k) : 32'(r_j)));
    assign w_b_addr = BA_W'((w_is_mul ? 32'(r_k) : 32'(r_i)) * N + 32'(r_j));
    assign w_r_addr = RA_W'(32'(r_i) * N + 32'(r_j));

    assign w_a_el = r_abuf[w_a_addr];
    assign w_b_el = r_bbuf[w_b_addr];
    assign w_ar   = ACC_W'($signed(w_a_el[2*W-1:W]));
    assign w_ai   = ACC_W'($signed(w_a_el[W-1:0]));
    assign w_br   = ACC_W'($signed(w_b_el[2*W-1:W]));
    assign w_bi   = ACC_W'($signed(w_b_el[W-1:0]));
    assign w_pre  = w_ar * w_br - w_ai * w_bi;
    assign w_pim  = w_ar * w_bi + w_ai * w_br;

    // Shared MAC result selection.
    always_comb begin
        w_vre = w_ar + w_br;
        w_vim = w_ai + w_bi;
        case (r_op)
            OP_ADD: begin
                w_vre = w_ar + w_br;
                w_vim = w_ai + w_bi;
            end
            OP_SUB: begin
                w_vre = w_ar - w_br;
                w_vim = w_ai - w_bi;
            end
            OP_MUL: begin
                w_vre = r_acc_re + w_pre;
                w_vim = r_acc_im + w_pim;
            end
            OP_HAD: begin
                w_vre = w_pre;
                w_vim = w_pim;
            end
        endcase
    end

    assign w_wr_data = {reduce_rw(w_vre), reduce_rw(w_vim)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start && w_legal)      w_next = S_LOAD;
            S_LOAD:    if (w_a_done && w_b_done)  w_next = S_COMPUTE;
            S_COMPUTE: if (w_cmp_last)            w_next = S_OUT;
            S_OUT:     if (res_ready && w_out_last) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Operand and result storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_a_take) r_abuf[r_a_cnt]  <= a_data;
        if (w_b_take) r_bbuf[r_b_cnt]  <= b_data;
        if (w_wr_en)  r_rbuf[w_r_addr] <= w_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= OP_ADD;
            r_a_cnt     <= '0;
            r_b_cnt     <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_oidx      <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_error <= (r_state == S_IDLE) && start && !w_legal;
            r_busy  <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op     <= op;
                        r_a_cnt  <= '0;
                        r_b_cnt  <= '0;
                        r_i      <= '0;
                        r_j      <= '0;
                        r_k      <= '0;
                        r_acc_re <= '0;
                        r_acc_im <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_a_take) r_a_cnt <= r_a_cnt + AA_W'(1);
                    if (w_b_take) r_b_cnt <= r_b_cnt + BA_W'(1);
                end
                S_COMPUTE: begin
                    if (!w_k_last) begin
                        r_k      <= r_k + KK_W'(1);
                        r_acc_re <= w_vre;
                        r_acc_im <= w_vim;
                    end else begin
                        r_k      <= '0;
                        r_acc_re <= '0;
                        r_acc_im <= '0;
                        if (w_col_last) begin
                            r_j <= '0;
                            r_i <= r_i + I_W'(1);
                        end else begin
                            r_j <= r_j + J_W'(1);
                        end
                    end
                    // Element 0 is only still in flight when the result is a single element.
                    if (w_cmp_last) begin
                        r_oidx      <= '0;
                        r_res_valid <= 1'b1;
                        r_res_last  <= (MN == 1);
                        r_res_data  <= (MN == 1) ? w_wr_data : r_rbuf[0];
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        if (w_out_last) begin
                            r_res_valid <= 1'b0;
                            r_res_last  <= 1'b0;
                        end else begin
                            r_oidx     <= w_oidx_nxt;
                            r_res_data <= r_rbuf[w_oidx_nxt];
                            r_res_last <= (w_oidx_nxt == RA_W'(MN - 1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_last  = r_res_last;
    assign busy      = r_busy;
    assign error     = r_error;

endmodule

// File: tb/tb_cmat_alu.sv
// Self-checking bench for cmat_alu: default 3x3x3 instance plus a 2x3x3, RW=8 instance.
module tb_cmat_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic [1:0]  op = 2'b00;
    logic        a_valid = 1'b0;
    logic [15:0] a_data = '0;
    logic        b_valid = 1'b0;
    logic [15:0] b_data = '0;
    logic        res_ready = 1'b0;

    logic        res_valid1, res_last1, busy1, error1;
    logic [39:0] res_data1;
    logic        res_valid2, res_last2, busy2, error2;
    logic [15:0] res_data2;

    logic        sel = 1'b0;
    logic        valid_m, last_m, busy_m, error_m;
    logic [63:0] data_m;

    int n_err = 0;
    int n_chk = 0;
    int are[9], aim[9], bre[9], bim[9];

    always #5 clk = ~clk;

    cmat_alu u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op),
        .a_valid(a_valid), .a_data(a_data), .b_valid(b_valid), .b_data(b_data),
        .res_ready(res_ready), .res_valid(res_valid1), .res_data(res_data1),
        .res_last(res_last1), .busy(busy1), .error(error1)
    );

    cmat_alu #(.M(2), .K(3), .N(3), .W(8), .RW(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .op(op),
        .a_valid(a_valid), .a_data(a_data), .b_valid(b_valid), .b_data(b_data),
        .res_ready(res_ready), .res_valid(res_valid2), .res_data(res_data2),
        .res_last(res_last2), .busy(busy2), .error(error2)
    );

    assign valid_m = sel ? res_valid2 : res_valid1;
    assign last_m  = sel ? res_last2  : res_last1;
    assign busy_m  = sel ? busy2      : busy1;
    assign error_m = sel ? error2     : error1;
    assign data_m  = sel ? 64'(res_data2) : 64'(res_data1);

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] pk(input int re, input int im);
        return {8'(re), 8'(im)};
    endfunction

    // Result component reduced to rw bits, returned as its rw-bit pattern.
    function automatic longint red(input longint v, input int rw);
        longint mx, mn, r;
        mx = (longint'(1) <<< (rw - 1)) - 1;
        mn = -mx - 1;
        r  = v;
`ifdef CMAT_SAT_EN
        if (r > mx) r = mx;
        if (r < mn) r = mn;
`endif
        return r & ((longint'(1) <<< rw) - 1);
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 9; i++) begin
            are[i] = int'($urandom_range(0, 255)) - 128;
            aim[i] = int'($urandom_range(0, 255)) - 128;
            bre[i] = int'($urandom_range(0, 255)) - 128;
            bim[i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    task automatic fill_const(input int ar, input int ai, input int br, input int bi);
        for (int i = 0; i < 9; i++) begin
            are[i] = ar; aim[i] = ai; bre[i] = br; bim[i] = bi;
        end
    endtask

    // One full transaction: start, randomly paced load, compute timing, checked drain.
    task automatic run_txn(input bit s, input logic [1:0] o, input int ready_pct, input int stall_at);
        int m, n, kk, rw, na, nb, nr, clen, ai, bi, cyc, idx, stalls;
        longint sr, si;
        bit rdy;
        longint exp_q[$];
        m = s ? 2 : 3; kk = 3; n = 3; rw = s ? 8 : 20;
        na = m * kk; nb = kk * n; nr = m * n;
        clen = (o == 2'b10) ? nr * kk : nr;
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < n; j++) begin
                int e;
                e = i * n + j;
                case (o)
                    2'b00: begin sr = are[e] + bre[e]; si = aim[e] + bim[e]; end
                    2'b01: begin sr = are[e] - bre[e]; si = aim[e] - bim[e]; end
                    2'b11: begin
                        sr = are[e] * bre[e] - aim[e] * bim[e];
                        si = are[e] * bim[e] + aim[e] * bre[e];
                    end
                    default: begin
                        sr = 0; si = 0;
                        for (int k = 0; k < kk; k++) begin
                            sr += are[i*kk+k] * bre[k*n+j] - aim[i*kk+k] * bim[k*n+j];
                            si += are[i*kk+k] * bim[k*n+j] + aim[i*kk+k] * bre[k*n+j];
                        end
                    end
                endcase
                exp_q.push_back((red(sr, rw) << rw) | red(si, rw));
            end
        end

        sel = s;
        op  = o;
        if (s) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0;
        check_eq("busy_after_start", longint'(busy_m), 1);
        check_eq("error_after_start", longint'(error_m), 0);

        ai = 0; bi = 0; cyc = 0;
        while ((ai < na || bi < nb) && cyc < 500) begin
            a_valid = ($urandom_range(0, 3) != 0);
            b_valid = ($urandom_range(0, 3) != 0);
            a_data  = (ai < na) ? pk(are[ai], aim[ai]) : 16'($urandom);
            b_data  = (bi < nb) ? pk(bre[bi], bim[bi]) : 16'($urandom);
            @(posedge clk); #1;
            if (a_valid && ai < na) ai++;
            if (b_valid && bi < nb) bi++;
            cyc++;
        end
        a_valid = 1'b0; b_valid = 1'b0;

        cyc = 0;
        while (!valid_m && cyc < 1000) begin
            check_eq("busy_in_compute", longint'(busy_m), 1);
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("compute_cycles", cyc, clen);

        idx = 0; cyc = 0; stalls = 0;
        while (idx < nr && cyc < nr * 40 + 50) begin
            check_eq("res_valid", longint'(valid_m), 1);
            check_eq("res_data", longint'(data_m), exp_q[idx]);
            check_eq("res_last", longint'(last_m), (idx == nr - 1) ? 1 : 0);
            if (idx == stall_at && stalls < 5) begin
                rdy = 1'b0;
                stalls++;
            end else begin
                rdy = ($urandom_range(0, 99) < ready_pct);
            end
            res_ready = rdy;
            @(posedge clk); #1;
            if (rdy) idx++;
            cyc++;
        end
        res_ready = 1'b0;
        check_eq("handshakes", idx, nr);
        check_eq("busy_after_last", longint'(busy_m), 0);
        check_eq("valid_after_last", longint'(valid_m), 0);
    endtask

    initial begin
        #12;
        check_eq("rst_valid1", longint'(res_valid1), 0);
        check_eq("rst_data1",  longint'(res_data1), 0);
        check_eq("rst_last1",  longint'(res_last1), 0);
        check_eq("rst_busy1",  longint'(busy1), 0);
        check_eq("rst_error1", longint'(error1), 0);
        check_eq("rst_busy2",  longint'(busy2), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Add with constant operands: (2+1j) + (1+3j) = 3+4j.
        fill_const(2, 1, 1, 3);
        run_txn(1'b0, 2'b00, 100, -1);

        // Identity times B returns B.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                are[r*3+c] = (r == c) ? 1 : 0;
                aim[r*3+c] = 0;
                bre[r*3+c] = r + 1;
                bim[r*3+c] = c - 1;
            end
        end
        run_txn(1'b0, 2'b10, 100, -1);

        // Hadamard (1+2j)(3+4j) = -5+10j.
        fill_const(1, 2, 3, 4);
        run_txn(1'b0, 2'b11, 100, -1);

        // Backpressure: five stall cycles mid-stream.
        fill_random();
        run_txn(1'b0, 2'b01, 100, 4);

        // Non-square element-wise op is rejected with a single error pulse.
        sel = 1'b1;
        op = 2'b00;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        check_eq("err_pulse", longint'(error2), 1);
        check_eq("err_busy", longint'(busy2), 0);
        @(posedge clk); #1;
        check_eq("err_pulse_end", longint'(error2), 0);
        check_eq("err_busy_end", longint'(busy2), 0);
        fill_random();
        run_txn(1'b1, 2'b10, 80, -1);

        // Narrow result: 3 * 127 * 127 = 48387 overflows RW=8.
        fill_const(127, 0, 127, 0);
        run_txn(1'b1, 2'b10, 100, -1);

        // Reset in the middle of LOAD.
        sel = 1'b0;
        op = 2'b00;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1;
            a_data  = 16'($urandom);
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        check_eq("busy_before_reset", longint'(busy1), 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", longint'(res_valid1), 0);
        check_eq("mid_rst_data",  longint'(res_data1), 0);
        check_eq("mid_rst_last",  longint'(res_last1), 0);
        check_eq("mid_rst_busy",  longint'(busy1), 0);
        check_eq("mid_rst_error", longint'(error1), 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_random();
        run_txn(1'b0, 2'b00, 100, -1);

        // Randomized transactions, back to back.
        for (int t = 0; t < 14; t++) begin
            fill_random();
            run_txn(1'b0, 2'($urandom_range(0, 3)), int'($urandom_range(30, 100)), -1);
        end
        for (int t = 0; t < 3; t++) begin
            fill_random();
            run_txn(1'b1, 2'b10, int'($urandom_range(30, 100)), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
